// File: rtl/bsg_mem_1rw_sync_mask_write_byte_req_adapter_if.sv
// Request, memory-pin and response signals of the byte-masked-write
// memory request adapter, bundled so that requester, adapter and memory
// share one set of declarations.
//
// Handshake semantics:
// - A request transfers on any rising clk edge where v_i & ready_o.
// - ready_o depends only on registered state. Once v_i is raised, the
//   request fields must stay stable until that transfer.
// - A response transfers on any rising clk edge where v_o & yumi_i.
// - yumi_i may only be raised while v_o=1.
interface bsg_mem_1rw_sync_mask_write_byte_req_adapter_if #(
    parameter int width_p = 32,
    parameter int els_p   = 16
) ();
    localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p);
    localparam int mask_width_lp = width_p >> 3;

    // request side
    logic                     v_i;
    logic                     ready_o;
    logic                     w_i;
    logic [addr_width_lp-1:0] addr_i;
    logic [width_p-1:0]       data_i;
    logic [mask_width_lp-1:0] w_mask_i;

    // memory side
    logic                     mem_v_o;
    logic                     mem_w_o;
    logic [addr_width_lp-1:0] mem_addr_o;
    logic [width_p-1:0]       mem_data_o;
    logic [mask_width_lp-1:0] mem_w_mask_o;
    logic [width_p-1:0]       mem_data_i;

    // response side
    logic                     v_o;
    logic [width_p-1:0]       data_o;
    logic                     yumi_i;

    // adapter view
    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i, mem_data_i, yumi_i,
        output ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o,
        output v_o, data_o
    );

    // requester + memory view (the environment around the adapter)
    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i, mem_data_i, yumi_i,
        input  ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o,
        input  v_o, data_o
    );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_req_adapter.sv
// Front end for a single-port synchronous byte-masked-write memory.
// Requests pass straight to the memory pins on acceptance. The read data
// arriving one cycle later is either handed out directly (bypass) or
// parked in a small response FIFO. Requests are only accepted while a
// FIFO slot is guaranteed for every read in flight, so no read data is
// ever dropped.
module bsg_mem_1rw_sync_mask_write_byte_req_adapter #(
    parameter int width_p   = 32,
    parameter int els_p     = 16,
    parameter int rsp_els_p = 2
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_mem_1rw_sync_mask_write_byte_req_adapter_if.slave bus
);
    localparam int ptr_width_lp = (rsp_els_p > 1) ? $clog2(rsp_els_p) : 1;
    localparam int cnt_width_lp = $clog2(rsp_els_p + 1);

    logic [width_p-1:0]      fifo_r [rsp_els_p];
    logic [ptr_width_lp-1:0] wptr_r;
    logic [ptr_width_lp-1:0] rptr_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    rd_pend_r;

    logic fifo_empty;
    logic accept;
    logic enq;
    logic deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (32'(p) == rsp_els_p - 1) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (cnt_r == '0);

    // Credit check: every buffered entry and every read in flight holds a slot.
    assign bus.ready_o = (32'(cnt_r) + 32'(rd_pend_r)) < rsp_els_p;

    // Reset gating keeps the memory idle while reset is held.
    assign accept = bus.v_i & bus.ready_o & reset_n_i;

    assign bus.mem_v_o      = accept;
    assign bus.mem_w_o      = bus.w_i;
    assign bus.mem_addr_o   = bus.addr_i;
    assign bus.mem_data_o   = bus.data_i;
    assign bus.mem_w_mask_o = bus.w_mask_i;

    // FIFO head always predates in-flight data; bypass only when empty.
    assign bus.v_o    = ~fifo_empty | rd_pend_r;
    assign bus.data_o = ~fifo_empty ? fifo_r[rptr_r]
                      : (rd_pend_r ? bus.mem_data_i : '0);

    // Bypassed data consumed the same cycle never touches the FIFO.
    assign enq = rd_pend_r & ~(fifo_empty & bus.yumi_i);
    assign deq = bus.yumi_i & ~fifo_empty;

    // Read-pending flag, FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pend_r <= 1'b0;
            wptr_r    <= '0;
            rptr_r    <= '0;
            cnt_r     <= '0;
            for (int i = 0; i < rsp_els_p; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            rd_pend_r <= accept & ~bus.w_i;
            if (enq) begin
                fifo_r[wptr_r] <= bus.mem_data_i;
                wptr_r         <= ptr_inc(wptr_r);
            end
            if (deq) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({enq, deq})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Simulation-only protocol and configuration checks.
    a_cfg : assert property (@(posedge clk_i) ((width_p % 8) == 0) && (rsp_els_p >= 1));
    a_yumi : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.yumi_i |-> bus.v_o);
    a_addr : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        accept |-> (32'(bus.addr_i) < els_p));
    a_known : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !$isunknown({bus.v_i, bus.yumi_i}));
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_req_adapter.sv
// Bench for the byte-masked memory request adapter: a behavioural memory
// sits on the memory pins, a reference word array predicts read results,
// and a monitor consumes responses and checks them against a queue.
module tb_bsg_mem_1rw_sync_mask_write_byte_req_adapter;
    localparam int width_p   = 32;
    localparam int els_p     = 16;
    localparam int rsp_els_p = 2;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bsg_mem_1rw_sync_mask_write_byte_req_adapter_if #(
        .width_p(width_p), .els_p(els_p)
    ) bus ();

    bsg_mem_1rw_sync_mask_write_byte_req_adapter #(
        .width_p(width_p), .els_p(els_p), .rsp_els_p(rsp_els_p)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    // ---------------- behavioural memory on the pins ----------------
    logic [31:0] mem_arr [els_p];
    logic [31:0] mem_rdata;
    assign bus.mem_data_i = mem_rdata;

    always @(posedge clk_i) begin
        if (bus.mem_v_o) begin
            if (bus.mem_w_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.mem_w_mask_o[k]) mem_arr[bus.mem_addr_o][8*k +: 8] <= bus.mem_data_o[8*k +: 8];
                end
            end else begin
                mem_rdata <= mem_arr[bus.mem_addr_o];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [els_p];
    logic [width_p-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int yumi_pct = 100;
    int yumi_credits = 0;
    int run_len = 0;
    int max_run = 0;
    bit take;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- response monitor ----------------
    initial begin
        bus.yumi_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                bus.yumi_i = 1'b0;
                run_len = 0;
            end else begin
                if (bus.v_o) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                take = bus.v_o && (yumi_credits > 0 || int'($urandom_range(0, 99)) < yumi_pct);
                if (take) begin
                    if (yumi_credits > 0) yumi_credits--;
                    if (exp_q.size() == 0) bound_fail("rsp_unexpected");
                    else check("rsp_data", bus.data_o, exp_q.pop_front());
                end
                bus.yumi_i = take;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit w, input int a, input logic [31:0] d, input logic [3:0] m,
                        output int stalls);
        stalls = 0;
        @(negedge clk_i);
        bus.v_i = 1'b1;
        bus.w_i = w;
        bus.addr_i = a[3:0];
        bus.data_i = d;
        bus.w_mask_i = m;
        while (!bus.ready_o && stalls < 100) begin
            @(negedge clk_i);
            stalls++;
        end
        if (!bus.ready_o) begin
            bound_fail("send_ready");
            bus.v_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 bus.v_i = 1'b0;
        if (w) ref_mem[a] = merge(ref_mem[a], d, m);
        else exp_q.push_back(ref_mem[a]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        yumi_pct = 100;
        while ((exp_q.size() != 0 || bus.v_o) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 300) bound_fail("drain");
        repeat (2) @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    int st;
    int total_stall;
    logic [31:0] e_b;

    initial begin
        bus.v_i = 1'b0;
        bus.w_i = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.w_mask_i = '0;
        mem_rdata = '0;
        for (int i = 0; i < els_p; i++) begin
            mem_arr[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
            ref_mem[i] = mem_arr[i];
        end

        // reset values, and no memory access while reset is held
        reset_n_i = 1'b1;
        #1 reset_n_i = 1'b0;
        #2 bus.v_i = 1'b1;
        #1;
        check("rst_mem_v", bus.mem_v_o, 0);
        check("rst_ready", bus.ready_o, 1);
        check("rst_v_o", bus.v_o, 0);
        check("rst_data_o", bus.data_o, 0);
        bus.v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;

        // write then read, response one cycle after acceptance
        send(1'b1, 3, 32'hDEADBEEF, 4'b1111, st);
        send(1'b0, 3, 32'h0, 4'b0, st);
        @(negedge clk_i);
        check("wr_rd_v", bus.v_o, 1);
        check("wr_rd_data", bus.data_o, 32'hDEADBEEF);
        drain();

        // partial byte write
        send(1'b1, 5, 32'h11223344, 4'b1111, st);
        send(1'b1, 5, 32'hAABBCCDD, 4'b0101, st);
        send(1'b0, 5, 32'h0, 4'b0, st);
        @(negedge clk_i);
        check("partial_data", bus.data_o, 32'h11BB33DD);
        drain();

        // zero-mask write leaves the word alone
        send(1'b1, 5, 32'hFFFF_FFFF, 4'b0000, st);
        send(1'b0, 5, 32'h0, 4'b0, st);
        @(negedge clk_i);
        check("zero_mask_data", bus.data_o, 32'h11BB33DD);
        drain();

        // backpressure with the FIFO filling up
        yumi_pct = 0;
        send(1'b0, 0, 32'h0, 4'b0, st);
        send(1'b0, 1, 32'h0, 4'b0, st);
        @(negedge clk_i);
        check("bp_ready_low", bus.ready_o, 0);
        fork
            send(1'b0, 2, 32'h0, 4'b0, st);
            begin
                repeat (3) @(negedge clk_i);
                check("bp_stalled_ready", bus.ready_o, 0);
                check("bp_head_data", bus.data_o, ref_mem[0]);
                @(posedge clk_i);
                #1 yumi_credits = 1;
                @(negedge clk_i);
                check("bp_no_comb_rise", bus.ready_o, 0);
                @(negedge clk_i);
                check("bp_ready_rise", bus.ready_o, 1);
            end
        join
        check("bp_read2_stalled", st > 0, 1);
        drain();

        // streaming reads through the bypass path
        max_run = 0;
        total_stall = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, i + 8, 32'h0, 4'b0, st);
            total_stall += st;
        end
        drain();
        check("stream_stalls", total_stall, 0);
        check("stream_run", max_run, 8);

        // enqueue and dequeue in the same cycle
        yumi_pct = 0;
        send(1'b0, 9, 32'h0, 4'b0, st);
        send(1'b0, 10, 32'h0, 4'b0, st);
        e_b = ref_mem[10];
        yumi_credits = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("sim_v", bus.v_o, 1);
        check("sim_ready", bus.ready_o, 1);
        check("sim_head", bus.data_o, e_b);
        drain();

        // randomized traffic with random response backpressure
        yumi_pct = 60;
        for (int n = 0; n < 150; n++) begin
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, els_p - 1)), $urandom,
                 4'($urandom), st);
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
        end
        drain();

        // asynchronous reset with two buffered responses
        send(1'b1, 7, 32'h0BADF00D, 4'b1111, st);
        drain();
        yumi_pct = 0;
        send(1'b0, 1, 32'h0, 4'b0, st);
        send(1'b0, 2, 32'h0, 4'b0, st);
        @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        check("arst_v_o", bus.v_o, 0);
        check("arst_ready", bus.ready_o, 1);
        exp_q.delete();
        bus.v_i = 1'b1;
        bus.w_i = 1'b1;
        bus.addr_i = 4'd7;
        bus.data_i = 32'h0;
        bus.w_mask_i = 4'b1111;
        #1 check("arst_no_mem_access", bus.mem_v_o, 0);
        repeat (2) @(negedge clk_i);
        bus.v_i = 1'b0;
        bus.w_i = 1'b0;
        reset_n_i = 1'b1;
        yumi_pct = 100;
        send(1'b0, 7, 32'h0, 4'b0, st);
        @(negedge clk_i);
        check("arst_retained", bus.data_o, 32'h0BADF00D);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // overall time bound
    initial begin
        #1000000;
        bound_fail("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_byte_req_adapter.md
Name: bsg_mem_1rw_sync_mask_write_byte_req_adapter

Overview:
- Request/response front end that sits directly upstream of the single-port synchronous byte-masked-write memory.
- Accepts ready/valid read and write requests, drives the memory's v/w/addr/data/byte-mask pins, and captures the one-cycle-late read data.
- Returns read data on a valid/yumi response port, with a small response FIFO and credit-based backpressure so no read data is ever dropped.

Parameters:
- width_p, none (required), data width in bits; must be a multiple of 8.
- els_p, none (required), number of memory words.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width.
- mask_width_lp, width_p>>3, byte-mask width.
- rsp_els_p, 2, response FIFO depth; must be >= 1.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  request valid
- ready_o  out  1  request ready
- w_i  in  1  1 = write, 0 = read
- addr_i  in  addr_width_lp  request address
- data_i  in  width_p  write data
- w_mask_i  in  mask_width_lp  byte write enables; bit k covers data bits [8k+7:8k]
- mem_v_o  out  1  memory access enable
- mem_w_o  out  1  memory write enable
- mem_addr_o  out  addr_width_lp  memory address
- mem_data_o  out  width_p  memory write data
- mem_w_mask_o  out  mask_width_lp  memory byte mask
- mem_data_i  in  width_p  memory read data, valid the cycle after a read
- v_o  out  1  response valid
- data_o  out  width_p  read response data
- yumi_i  in  1  response consumed; legal only when v_o=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i. Assertion of reset_n_i=0 immediately clears all state.
- Reset values: ready_o=1, v_o=0, mem_v_o=0, data_o=0. FIFO count and pointers are 0, rd_pend_r=0.
- Request handshake:
  - A request is accepted when v_i & ready_o.
  - ready_o is registered-state-only: ready_o = (fifo_cnt + rd_pend_r) < rsp_els_p. It does not depend on w_i, v_i or yumi_i.
- Memory drive (combinational, same cycle as acceptance):
  - mem_v_o = v_i & ready_o; mem_w_o = w_i.
  - addr, data and mask pass straight through to mem_addr_o, mem_data_o and mem_w_mask_o.
  - When no request is accepted, mem_v_o=0 and the other outputs are don't-care.
- Writes: no response is produced. A write with w_mask_i=0 is still issued to memory and leaves the word unchanged.
- Reads:
  - An accepted read sets rd_pend_r=1 for the next cycle; otherwise rd_pend_r=0.
  - In the cycle where rd_pend_r=1, mem_data_i is the read data.
- Response path, minimum latency 1 cycle from acceptance:
  - FIFO empty and rd_pend_r=1: bypass. v_o=1, data_o=mem_data_i. If yumi_i=1 the data is not enqueued; otherwise it is enqueued at wptr.
  - FIFO non-empty: v_o=1, data_o=fifo[rptr]. If rd_pend_r=1, mem_data_i is enqueued. If yumi_i=1, the head is dequeued.
  - Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo rsp_els_p.
- Ordering: responses are returned strictly in request order. The FIFO head always predates in-flight data.
- Credit invariant: fifo_cnt + rd_pend_r <= rsp_els_p at all times, so an overflow cannot occur.
- Full: with fifo_cnt=rsp_els_p, ready_o=0. ready_o rises the cycle after a yumi frees an entry; it does not rise combinationally.
- Reset mid-operation:
  - In-flight reads and buffered responses are discarded.
  - Memory contents are not touched, and no memory access is issued while reset is held.
- Assertions (simulation only):
  - yumi_i while v_o=0.
  - addr_i >= els_p on an accepted request.
  - width_p % 8 != 0.
  - X on v_i or yumi_i out of reset.

Test Plan:
- Write then read, with els_p=16, width_p=32: write addr 3, data 0xDEADBEEF, mask 4'b1111, then read addr 3 with yumi_i held 1. Required: v_o=1 exactly 1 cycle after the read is accepted, data_o=0xDEADBEEF.
- Partial write: preload addr 5 with 0x11223344, then write 0xAABBCCDD with mask 4'b0101. Required: a read of addr 5 returns 0x11BB33DD.
- Backpressure, with rsp_els_p=2 and yumi_i=0: issue reads to addrs 0, 1 and 2 back-to-back.
  - Required: reads 0 and 1 are accepted; ready_o=0 from the cycle after the second accept; read 2 is stalled.
  - Then pulse yumi_i once. Required: addr 0's data is returned; ready_o=1 the next cycle; read 2 is accepted; responses arrive in order 0, 1, 2.
- Streaming: 8 back-to-back reads with yumi_i=1 every cycle. Required: ready_o stays 1, 8 consecutive v_o cycles, and the FIFO stays empty (bypass path).
- Simultaneous events: with the FIFO holding 1 entry, a pending read, and yumi_i=1 in the same cycle. Required: count stays 1 and the ordering is preserved.
- Async reset: drop reset_n_i mid-cycle while 2 responses are buffered. Required: v_o=0 and ready_o=1 immediately. After release, a read of a previously written address returns the prior data.
